// File: rtl/core_btb_pkg.sv
// Shared definitions for the set-associative BTB: branch type codes,
// sequencer state encoding and the tag hash used by lookup and update.
package core_btb_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } btb_state_e;

    // XOR-fold pc[31:index_w+2] into tag_w bits, LSB chunk first; the last
    // chunk is implicitly zero-padded. Callers keep the low tag_w bits.
    function automatic logic [31:0] tag_hash(input logic [31:0] pc,
                                             input int          index_w,
                                             input int          tag_w);
        logic [31:0] h;
        int          j;
        h = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= index_w + 2) begin
                j = (i - index_w - 2) % tag_w;
                h[j[4:0]] = h[j[4:0]] ^ pc[i];
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/core_btb_way.sv
// One BTB way: valid bits, tag and target/type storage, a write port,
// a clear-by-index port and two combinational read/compare ports.
module core_btb_way
    import core_btb_pkg::*;
#(
    parameter int INDEX_W  = 6,
    parameter int TAG_W    = 11,
    parameter int TARGET_W = 30
) (
    input  logic                clk,
    input  logic                clr_en,
    input  logic [INDEX_W-1:0]  clr_idx,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [TARGET_W-1:0] wr_target,
    input  logic [1:0]          wr_type,
    input  logic                inv_en,
    input  logic [INDEX_W-1:0]  inv_idx,
    input  logic [INDEX_W-1:0]  lk_idx,
    input  logic [TAG_W-1:0]    lk_tag,
    output logic                lk_hit,
    output logic [TARGET_W-1:0] lk_target,
    output logic [1:0]          lk_type,
    input  logic [INDEX_W-1:0]  up_idx,
    input  logic [TAG_W-1:0]    up_tag,
    output logic                up_hit,
    output logic                up_valid
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]     valid_reg;
    logic [TAG_W-1:0]    tag_mem    [SETS];
    logic [TARGET_W-1:0] target_mem [SETS];
    logic [1:0]          type_mem   [SETS];

    // Clear, invalidate and write never coincide: the clear runs only while
    // the sequencer is busy and the other two only while it is idle.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_reg[clr_idx] <= 1'b0;
        end else if (inv_en) begin
            valid_reg[inv_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            type_mem[wr_idx]   <= wr_type;
        end
    end

    assign lk_hit    = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_target = target_mem[lk_idx];
    assign lk_type   = type_mem[lk_idx];

    assign up_valid  = valid_reg[up_idx];
    assign up_hit    = valid_reg[up_idx] && (tag_mem[up_idx] == up_tag);

endmodule

// File: rtl/core_btb_assoc.sv
// Set-associative branch target buffer: same-cycle lookup on the fetch PC,
// registered update/invalidate port, clear sequencer and per-set round-robin.
module core_btb_assoc
    import core_btb_pkg::*;
#(
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 2,
    parameter int TAG_W    = 11,
    parameter int TARGET_W = 30,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             PHT_pred_taken,
    input  logic             upd_en,
    input  logic             upd_inv,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic [1:0]       upd_type,
    input  logic             flush,
    output logic             btb_v,
    output logic [31:0]      btb_target_out,
    output logic [1:0]       btb_type_out,
    output logic [WAY_W-1:0] btb_hit_way,
    output logic             en_btb_pred,
    output logic             btb_busy
);
    localparam int SETS = 1 << INDEX_W;

    btb_state_e         state_reg;
    logic [INDEX_W-1:0] clr_idx_reg;
    logic [WAY_W-1:0]   rr_reg [SETS];

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    logic [WAYS-1:0]     lk_hit, up_hit, up_valid, wr_en, inv_en;
    logic [TARGET_W-1:0] lk_target [WAYS];
    logic [1:0]          lk_type   [WAYS];

    logic             up_any, free_any, do_upd, inv_fire, wr_fire, rr_bump;
    logic [WAY_W-1:0] up_way, free_way, victim;

    logic             sel_hit;
    logic [WAY_W-1:0] sel_way;
    logic [TARGET_W-1:0] sel_target;
    logic [1:0]       sel_type;

    logic unused_target_lsbs;
    assign unused_target_lsbs = ^upd_target[1:0];

    assign lk_idx = pc[INDEX_W+1:2];
    assign up_idx = upd_pc[INDEX_W+1:2];
    assign lk_tag = TAG_W'(tag_hash(pc, INDEX_W, TAG_W));
    assign up_tag = TAG_W'(tag_hash(upd_pc, INDEX_W, TAG_W));

    assign btb_busy = (state_reg == CLEAR);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign wr_en[gi]  = wr_fire  && (victim == WAY_W'(gi));
            assign inv_en[gi] = inv_fire && (up_way == WAY_W'(gi));

            core_btb_way #(
                .INDEX_W  (INDEX_W),
                .TAG_W    (TAG_W),
                .TARGET_W (TARGET_W)
            ) u_way (
                .clk       (clk),
                .clr_en    (btb_busy),
                .clr_idx   (clr_idx_reg),
                .wr_en     (wr_en[gi]),
                .wr_idx    (up_idx),
                .wr_tag    (up_tag),
                .wr_target (upd_target[TARGET_W+1:2]),
                .wr_type   (upd_type),
                .inv_en    (inv_en[gi]),
                .inv_idx   (up_idx),
                .lk_idx    (lk_idx),
                .lk_tag    (lk_tag),
                .lk_hit    (lk_hit[gi]),
                .lk_target (lk_target[gi]),
                .lk_type   (lk_type[gi]),
                .up_idx    (up_idx),
                .up_tag    (up_tag),
                .up_hit    (up_hit[gi]),
                .up_valid  (up_valid[gi])
            );
        end
    endgenerate

    // Scanning from the top way down leaves the lowest matching/free way selected.
    always_comb begin
        up_any   = 1'b0;
        up_way   = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_hit[w]) begin
                up_any = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!up_valid[w]) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign do_upd   = (state_reg == RUN) && !flush;
    assign inv_fire = do_upd && upd_inv && up_any;
    assign wr_fire  = do_upd && upd_en && !upd_inv;
    assign rr_bump  = wr_fire && !up_any && !free_any;
    assign victim   = up_any ? up_way : (free_any ? free_way : rr_reg[up_idx]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
            end
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (flush) begin
                        clr_idx_reg <= '0;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + 1'b1;
                        if (clr_idx_reg == INDEX_W'(SETS - 1)) begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= '0;
                    end else if (WAYS > 1 && rr_bump) begin
                        rr_reg[up_idx] <= rr_reg[up_idx] + 1'b1;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    always_comb begin
        sel_hit    = 1'b0;
        sel_way    = '0;
        sel_target = '0;
        sel_type   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_hit[w]) begin
                sel_hit    = 1'b1;
                sel_way    = WAY_W'(w);
                sel_target = lk_target[w];
                sel_type   = lk_type[w];
            end
        end
    end

    // Outputs are forced to a clean miss while busy so stale or unwritten
    // array contents never leak out.
    always_comb begin
        btb_v          = 1'b0;
        btb_target_out = '0;
        btb_type_out   = '0;
        btb_hit_way    = '0;
        if (!btb_busy && sel_hit) begin
            btb_v          = 1'b1;
            btb_target_out = 32'({sel_target, 2'b00});
            btb_type_out   = sel_type;
            btb_hit_way    = sel_way;
        end
    end

    assign en_btb_pred = btb_v && PHT_pred_taken;

endmodule

// File: tb/tb_core_btb_assoc.sv
// Self-checking bench for core_btb_assoc: directed scenarios plus random
// traffic, checked against a per-set/per-way behavioural model.
module tb_core_btb_assoc;
    localparam int INDEX_W = 6;
    localparam int WAYS    = 2;
    localparam int TAG_W   = 11;
    localparam int SETS    = 1 << INDEX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        PHT_pred_taken;
    logic        upd_en, upd_inv, flush;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic        btb_v, en_btb_pred, btb_busy;
    logic [31:0] btb_target_out;
    logic [1:0]  btb_type_out;
    logic [0:0]  btb_hit_way;

    always #10 clk = ~clk;

    core_btb_assoc #(
        .INDEX_W  (INDEX_W),
        .WAYS     (WAYS),
        .TAG_W    (TAG_W),
        .TARGET_W (30)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .PHT_pred_taken (PHT_pred_taken),
        .upd_en         (upd_en),
        .upd_inv        (upd_inv),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_type       (upd_type),
        .flush          (flush),
        .btb_v          (btb_v),
        .btb_target_out (btb_target_out),
        .btb_type_out   (btb_type_out),
        .btb_hit_way    (btb_hit_way),
        .en_btb_pred    (en_btb_pred),
        .btb_busy       (btb_busy)
    );

    int tests = 0;
    int fails = 0;

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    logic [1:0]  m_type  [SETS][WAYS];
    int          m_rr    [SETS];
    int          busy_left;

    function automatic int unsigned ref_hash(input logic [31:0] a);
        int unsigned x, h;
        x = a >> (INDEX_W + 2);
        h = 0;
        while (x != 0) begin
            h = h ^ (x & ((1 << TAG_W) - 1));
            x = x >> TAG_W;
        end
        return h;
    endfunction

    function automatic int ref_set(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic int ref_find(input logic [31:0] a);
        int s;
        s = ref_set(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == ref_hash(a)) return w;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          w, s;
        logic [31:0] e_tgt;
        logic [1:0]  e_type;
        logic        e_v;
        w = (busy_left > 0) ? -1 : ref_find(pc);
        s = ref_set(pc);
        e_v    = (w >= 0);
        e_tgt  = e_v ? (m_tgt[s][w] & 32'hFFFF_FFFC) : 32'h0;
        e_type = e_v ? m_type[s][w] : 2'b00;
        chk("busy",   32'(btb_busy),       32'(busy_left > 0));
        chk("v",      32'(btb_v),          32'(e_v));
        chk("target", btb_target_out,      e_tgt);
        chk("type",   32'(btb_type_out),   32'(e_type));
        chk("way",    32'(btb_hit_way),    e_v ? 32'(w) : 32'h0);
        chk("en",     32'(en_btb_pred),    32'(e_v && PHT_pred_taken));
    endtask

    task automatic model_edge();
        int s, w;
        if (!rst) begin
            busy_left = SETS;
            for (int i = 0; i < SETS; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < WAYS; j++) m_valid[i][j] = 1'b0;
            end
        end else if (busy_left > 0) begin
            busy_left = flush ? SETS : busy_left - 1;
        end else if (flush) begin
            busy_left = SETS;
            for (int i = 0; i < SETS; i++)
                for (int j = 0; j < WAYS; j++) m_valid[i][j] = 1'b0;
        end else if (upd_inv) begin
            w = ref_find(upd_pc);
            if (w >= 0) m_valid[ref_set(upd_pc)][w] = 1'b0;
        end else if (upd_en) begin
            s = ref_set(upd_pc);
            w = ref_find(upd_pc);
            if (w < 0) begin
                for (int j = WAYS - 1; j >= 0; j--)
                    if (!m_valid[s][j]) w = j;
                if (w < 0) begin
                    w = m_rr[s];
                    m_rr[s] = (m_rr[s] + 1) % WAYS;
                end
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = ref_hash(upd_pc);
            m_tgt[s][w]   = upd_target;
            m_type[s][w]  = upd_type;
        end
    endtask

    task automatic cyc();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        upd_en  = 1'b0;
        upd_inv = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic set_upd(input logic en, input logic inv, input logic [31:0] a,
                           input logic [31:0] t, input logic [1:0] ty);
        upd_en     = en;
        upd_inv    = inv;
        upd_pc     = a;
        upd_target = t;
        upd_type   = ty;
        flush      = 1'b0;
    endtask

    // Directed lookup with constant expectations, followed by a model-checked cycle.
    task automatic expect_hit(input string tag, input logic [31:0] a, input logic v, input int way);
        idle();
        pc = a;
        PHT_pred_taken = 1'b1;
        #2;
        chk({tag, "_v"}, 32'(btb_v), 32'(v));
        if (v) chk({tag, "_way"}, 32'(btb_hit_way), 32'(way));
        cyc();
    endtask

    logic [31:0] pool [10];
    int          r;
    int          busy_cycles;

    initial begin
        rst = 1'b0;
        pc = 32'h0;
        PHT_pred_taken = 1'b0;
        upd_pc = 32'h0;
        upd_target = 32'h0;
        upd_type = 2'b00;
        idle();
        busy_left = SETS;

        // Reset held for two edges, then exactly SETS busy cycles.
        @(posedge clk);
        model_edge();
        #1;
        cyc();
        rst = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < SETS + 4; i++) begin
            pc = $urandom;
            PHT_pred_taken = 1'b1;
            #1;
            if (btb_busy) busy_cycles++;
            cyc();
        end
        chk("busy_len", 32'(busy_cycles), 32'(SETS));

        // Allocate and hit.
        set_upd(1'b1, 1'b0, 32'h0000_1040, 32'h0000_2003, 2'b01);
        pc = 32'h0;
        cyc();
        idle();
        pc = 32'h0000_1040;
        PHT_pred_taken = 1'b1;
        #2;
        chk("alloc_target", btb_target_out, 32'h0000_2000);
        chk("alloc_type", 32'(btb_type_out), 32'h1);
        chk("alloc_en", 32'(en_btb_pred), 32'h1);
        cyc();

        // Conflict and round-robin replacement in set 0x10.
        set_upd(1'b1, 1'b0, 32'h0000_2040, 32'h0000_A000, 2'b10); cyc();
        expect_hit("A", 32'h0000_1040, 1'b1, 0);
        expect_hit("B", 32'h0000_2040, 1'b1, 1);
        set_upd(1'b1, 1'b0, 32'h0000_3040, 32'h0000_B000, 2'b00); cyc();
        expect_hit("A_evict", 32'h0000_1040, 1'b0, 0);
        expect_hit("C", 32'h0000_3040, 1'b1, 0);
        set_upd(1'b1, 1'b0, 32'h0000_4040, 32'h0000_C000, 2'b11); cyc();
        expect_hit("B_evict", 32'h0000_2040, 1'b0, 0);
        expect_hit("D", 32'h0000_4040, 1'b1, 1);
        expect_hit("C2", 32'h0000_3040, 1'b1, 0);

        // Refresh in place, invalidate, then confirm rr was untouched.
        set_upd(1'b1, 1'b0, 32'h0000_4040, 32'h0000_9000, 2'b11); cyc();
        expect_hit("D_ref", 32'h0000_4040, 1'b1, 1);
        set_upd(1'b0, 1'b1, 32'h0000_4040, 32'h0, 2'b00); cyc();
        expect_hit("D_inv", 32'h0000_4040, 1'b0, 0);
        expect_hit("C3", 32'h0000_3040, 1'b1, 0);
        set_upd(1'b1, 1'b0, 32'h0000_5040, 32'h0000_5000, 2'b01); cyc();
        expect_hit("E", 32'h0000_5040, 1'b1, 1);
        set_upd(1'b1, 1'b0, 32'h0000_6040, 32'h0000_6000, 2'b10); cyc();
        expect_hit("C_evict", 32'h0000_3040, 1'b0, 0);
        expect_hit("F", 32'h0000_6040, 1'b1, 0);
        expect_hit("E2", 32'h0000_5040, 1'b1, 1);

        // Flush in RUN, again ten cycles into CLEAR, with an update dropped.
        idle(); flush = 1'b1; cyc();
        idle();
        for (int i = 0; i < 9; i++) cyc();
        flush = 1'b1; cyc();
        set_upd(1'b1, 1'b0, 32'h0000_7040, 32'h0000_7000, 2'b01); cyc();
        idle();
        busy_cycles = 1;
        for (int i = 0; i < SETS + 2; i++) begin
            pc = 32'h0000_5040;
            #1;
            if (btb_busy) busy_cycles++;
            cyc();
        end
        chk("flush_busy_len", 32'(busy_cycles), 32'(SETS));
        expect_hit("E_flushed", 32'h0000_5040, 1'b0, 0);
        expect_hit("F_flushed", 32'h0000_6040, 1'b0, 0);
        expect_hit("clr_upd_dropped", 32'h0000_7040, 1'b0, 0);

        // Same-cycle hazard and PHT gating.
        set_upd(1'b1, 1'b0, 32'h0000_0888, 32'h0000_1234, 2'b10);
        pc = 32'h0000_0888;
        PHT_pred_taken = 1'b0;
        #2;
        chk("hazard_miss", 32'(btb_v), 32'h0);
        cyc();
        idle();
        #2;
        chk("hazard_hit", 32'(btb_v), 32'h1);
        chk("pht_gate", 32'(en_btb_pred), 32'h0);
        cyc();

        // Random traffic concentrated on a few sets.
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 2);
            pool[i] = ($urandom & 32'hFFFF_FF00) | (32'(r == 0 ? 8'h10 : (r == 1 ? 8'h11 : 8'h3f)) << 2)
                      | 32'($urandom_range(0, 3));
        end
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            pc = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 9)];
            PHT_pred_taken = 1'($urandom);
            upd_pc     = pool[$urandom_range(0, 9)];
            upd_target = $urandom;
            upd_type   = 2'($urandom);
            upd_en     = (r < 45) || (r >= 50 && r < 55);
            upd_inv    = (r >= 45 && r < 55);
            flush      = ($urandom_range(0, 199) == 0);
            cyc();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_btb_assoc.md
Name: core_btb_assoc

Overview:
Parametrised set-associative branch target buffer for the core fetch stage.
- Same-cycle lookup on the fetch PC; an independent update port driven from branch resolution.
- Per-entry valid bits, a hardware clear sequencer for reset/flush, per-set round-robin replacement and single-entry invalidation.
- Drop-in successor to the direct-mapped BTB; the PHT gating output keeps the same meaning.

Parameters:
INDEX_W, 6, set index width; SETS = 2**INDEX_W; index = pc[INDEX_W+1:2]
WAYS, 2, associativity; legal values 1, 2, 4
TAG_W, 11, stored tag width
TARGET_W, 30, stored target bits pc[31:2]; target low 2 bits are always 0

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
pc  in  32  fetch PC for lookup
PHT_pred_taken  in  1  direction prediction for the fetch PC
upd_en  in  1  write or refresh the entry for upd_pc
upd_inv  in  1  invalidate the entry matching upd_pc; wins over upd_en
upd_pc  in  32  branch PC being updated
upd_target  in  32  resolved target; bits [1:0] ignored
upd_type  in  2  branch type code, stored verbatim
flush  in  1  clear all valid bits
btb_v  out  1  lookup hit
btb_target_out  out  32  {stored target, 2'b00}; 0 on miss
btb_type_out  out  2  stored type; 0 on miss
btb_hit_way  out  log2(WAYS) (min 1)  hitting way; 0 on miss
en_btb_pred  out  1  btb_v & PHT_pred_taken
btb_busy  out  1  clear sequence in progress

Behaviour:
- Tag: tag_hash(pc) = XOR-fold of pc[31:INDEX_W+2] into TAG_W bits, in TAG_W-bit chunks from the LSB up, zero-padding the last chunk. The same function is used for lookup and update.
- Storage per set/way: valid, tag, target, type. Per set: rr pointer, log2(WAYS) bits.
- Lookup is combinational and uses current array contents.
  - Hit means valid & tag match in any way.
  - If more than one way matches (unreachable by construction), the lowest way wins.
  - While btb_busy=1, all lookup outputs are forced to miss/0.
- FSM with states CLEAR and RUN.
  - rst=0 at a clock edge: state<=CLEAR, clr_idx<=0, all rr<=0. Outputs are then btb_busy=1, btb_v=0, en_btb_pred=0.
  - CLEAR: each cycle clears the valid bits of all ways of set clr_idx and increments clr_idx. At clr_idx=SETS-1 the FSM moves to RUN. The clear therefore takes exactly SETS cycles (64 at defaults); btb_busy drops the cycle after the last set is cleared.
  - RUN with flush=1: go to CLEAR with clr_idx<=0.
  - flush=1 while in CLEAR: restart with clr_idx<=0.
  - Updates arriving in CLEAR are dropped.
- Update in RUN (registered, visible to lookup the next cycle):
  - upd_inv=1 with a matching valid way: clear that valid bit. No match: no-op. rr unchanged in both cases.
  - upd_en=1 with a matching way: overwrite target and type in place. rr unchanged.
  - upd_en=1 with no match: allocate the lowest-numbered invalid way. If every way is valid, replace way rr[set] and set rr[set] <= rr+1 (wraps mod WAYS).
  - An allocated way gets valid=1, tag, target and type written.
- Simultaneous events:
  - Lookup and update on the same set in the same cycle: lookup returns the pre-update contents (no bypass).
  - flush together with upd_en: flush wins and the update is dropped.
  - upd_inv together with upd_en: invalidate only.
- WAYS=1 degenerates to direct-mapped: rr is unused and btb_hit_way is always 0.
- Arrays carry no reset beyond the valid bits. Tag, target and type may hold X until written, and must never propagate to outputs while valid=0.

Decomposition:
- Package core_btb_pkg holds:
  - tag_hash function, parameterised on INDEX_W and TAG_W;
  - branch type codes: BR_COND=2'b00, BR_JUMP=2'b01, BR_CALL=2'b10, BR_RET=2'b11;
  - FSM state encoding: CLEAR, RUN.
- Sub-module core_btb_way holds one way's storage: valid, tag and target/type arrays; write port; clear-by-index; combinational read plus tag compare. The top level instantiates WAYS copies and owns the FSM, rr pointers, victim select and output muxing.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → btb_busy=1 for exactly 64 cycles, then 0. Lookup of any pc during that window gives btb_v=0.
- Allocate and hit: upd_en with upd_pc=0x0000_1040, upd_target=0x0000_2003, upd_type=2'b01; next cycle pc=0x0000_1040, PHT_pred_taken=1 → btb_v=1, btb_target_out=0x0000_2000, btb_type_out=01, en_btb_pred=1.
- Conflict and replacement (WAYS=2): fill index 0x10 with tags A and B → both hit. Write tag C → way 0 evicted (rr 0→1) and A misses. Write tag D → way 1 evicted and B misses; C and D hit.
- Refresh and invalidate: upd_en on a hitting pc with a new target → same way, rr unchanged, new target read back. Then upd_inv on that pc → btb_v=0 next cycle; other ways of the set are unaffected.
- Flush mid-operation: entries valid, pulse flush in RUN and again 10 cycles into CLEAR → btb_busy stays 1 for 64 cycles after the second pulse and all prior entries miss. upd_en issued during CLEAR is not stored.
- Same-cycle hazard: lookup and upd_en on the same pc in one cycle → miss that cycle, hit the following cycle. PHT_pred_taken=0 on a hit → en_btb_pred=0 while btb_v=1.
